// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Fetch entries pair an instruction with the pc it was fetched from.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          DEPTH_DEF    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue between instruction memory responses and decode.
// Head is presented combinationally; flush empties the queue.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wdata,
  output fetch_entry_t               rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: pc generation, request credit and
// dropping of stale responses after a redirect.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  logic          run;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  wentry;

  assign target   = redirect_pc & 32'hFFFF_FFFC;
  assign used     = {1'b0, count} + {1'b0, outstanding};

  // run holds requests off until the first edge after reset
  assign imem_req_valid = run && !redirect_valid && (used < LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign pop    = !empty && inst_ready;
  assign push   = imem_resp_valid && !redirect_valid &&
                  (drop_cnt == '0) && (!full || pop);
  assign wentry = '{pc: resp_pc, inst: imem_resp_data};

  assign inst_valid = !empty;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + CW'(req_fire)
                   - CW'(imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (push)
          resp_pc <= resp_pc + 32'd4;
        if (imem_resp_valid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: in-order memory model
// with 1-cycle latency and an instruction scoreboard.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam int          DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  bit          c_ready;
  bit          c_resp_en;
  bit          c_iready;
  bit          c_redir;
  logic [31:0] c_redir_pc;

  pend_t       pend[$];
  pend_t       e;
  logic [31:0] sb_pc[$];
  logic [31:0] sb_inst[$];
  logic [31:0] log_pc[$];
  logic [31:0] exp_fetch;
  logic [31:0] epc;
  logic [31:0] einst;
  int          checks;
  int          errors;
  int          fires;

  always #5 clk = ~clk;

  ifetch #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  task automatic check(string tag, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] log_at(int i);
    return (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
  endfunction

  // memory model, scoreboard producer and consumer
  initial begin
    forever begin
      @(negedge clk);
      imem_req_ready = c_ready;
      inst_ready     = c_iready;
      if (rst) begin
        pend.delete();
        sb_pc.delete();
        sb_inst.delete();
        exp_fetch       = RPC;
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        continue;
      end
      redirect_valid = c_redir;
      redirect_pc    = c_redir_pc;
      c_redir        = 1'b0;
      if (redirect_valid) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        sb_pc.delete();
        sb_inst.delete();
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
      end
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      if (c_resp_en && pend.size() > 0) begin
        e = pend.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = ~e.addr;
        if (!e.stale) begin
          sb_pc.push_back(e.addr);
          sb_inst.push_back(~e.addr);
        end
      end
      #1;
      if (redirect_valid)
        check("redir_noreq", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_fetch);
        pend.push_back('{exp_fetch, 1'b0});
        exp_fetch = exp_fetch + 32'd4;
        fires++;
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        if (sb_pc.size() == 0) begin
          check("unexpected_inst", 32'(sb_pc.size()), 32'd1);
        end else begin
          epc   = sb_pc.pop_front();
          einst = sb_inst.pop_front();
          check("inst_pc", inst_pc, epc);
          check("inst", inst, einst);
        end
        log_pc.push_back(inst_pc);
      end
    end
  end

  initial begin
    c_ready = 0; c_resp_en = 1; c_iready = 1;
    c_redir = 0; c_redir_pc = 32'h0;
    imem_req_ready = 0; imem_resp_valid = 0;
    imem_resp_data = 0; redirect_valid = 0;
    redirect_pc = 0; inst_ready = 0;
    exp_fetch = RPC;
    checks = 0; errors = 0; fires = 0;

    rst = 1'b1;
    step(3);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    rst = 1'b0;
    #1;
    check("req_before_edge", 32'(imem_req_valid), 32'd0);

    // memory stalls: address must hold
    step(1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_req_addr, RPC);
      step(1);
    end
    check("stall_fires", 32'(fires), 32'd0);

    // streaming
    log_pc.delete();
    c_ready = 1;
    step(30);
    check("stream_0", log_at(0), RPC);
    check("stream_1", log_at(1), RPC + 32'd4);
    check("stream_2", log_at(2), RPC + 32'd8);
    check("stream_rate", 32'(log_pc.size() >= 15), 32'd1);

    // decode stalled from reset
    c_iready = 0;
    rst = 1'b1;
    step(2);
    fires = 0;
    rst = 1'b0;
    step(10);
    check("hold_fires", 32'(fires), 32'(DEPTH));
    check("hold_req_valid", 32'(imem_req_valid), 32'd0);
    check("hold_inst_valid", 32'(inst_valid), 32'd1);
    check("hold_head", inst_pc, RPC);
    log_pc.delete();
    c_iready = 1;
    step(10);
    check("release_0", log_at(0), RPC);
    check("release_1", log_at(1), RPC + 32'd4);
    check("release_2", log_at(2), RPC + 32'd8);

    // reset with a full queue
    c_iready = 0;
    step(6);
    check("full_inst_valid", 32'(inst_valid), 32'd1);
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_inst_pc", inst_pc, 32'd0);
    step(2);
    rst = 1'b0;
    log_pc.delete();
    c_iready = 1;
    step(10);
    check("restart_0", log_at(0), RPC);
    check("restart_1", log_at(1), RPC + 32'd4);

    // redirect with two requests in flight
    c_resp_en = 0;
    step(6);
    check("credit_req_valid", 32'(imem_req_valid), 32'd0);
    check("credit_inst_valid", 32'(inst_valid), 32'd0);
    log_pc.delete();
    c_redir    = 1;
    c_redir_pc = 32'h8000_1002;
    c_resp_en  = 1;
    step(1);
    check("redir_lat_1", 32'(inst_valid), 32'd0);
    step(1);
    check("redir_lat_2", 32'(inst_valid), 32'd0);
    step(20);
    check("redir_0", log_at(0), 32'h8000_1000);
    check("redir_1", log_at(1), 32'h8000_1004);

    // wrap at top of address space
    log_pc.delete();
    c_redir    = 1;
    c_redir_pc = 32'hFFFF_FFFC;
    step(20);
    check("wrap_0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_1", log_at(1), 32'h0000_0000);
    check("wrap_2", log_at(2), 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
